imem_loader: RTL and testbench

Instruction-memory program loader: the write side of the instruction memory that the fetch stage reads. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them to sequential word addresses of the instruction RAM and holds the CPU in reset until the image is complete. It replaces `$readmemh` image loading for synthesizable builds and sits between the host byte link and the instruction RAM write port.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 200 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream, instruction-RAM write and status signals of
// the program loader. "master" is the host/bench side, "slave" the loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  restart;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;
  logic [31:0]           end_pc;

  modport master (
    output restart, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, end_pc
  );

  modport slave (
    input  restart, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, end_pc
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a framed big-endian byte stream (16-bit word count,
// then payload) and writes 32-bit words to sequential instruction-RAM
// indices, holding the CPU in reset until the image is complete.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          ADDR_WIDTH  = 14,
  parameter logic [31:0] ADDR_OFFSET = 32'h3000
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);
  localparam int          WW  = ADDR_WIDTH - 2;
  localparam logic [16:0] CAP = 17'd1 << WW;

  localparam logic [2:0] S_HDR_HI    = 3'd0;
  localparam logic [2:0] S_HDR_LO    = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_DONE_WAIT = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM      = 3'd3;
`endif

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_hi_q, cnt_hi_d;
  logic [15:0]   rem_q, rem_d;
  logic [WW-1:0] idx_q, idx_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   shift_q, shift_d;
  logic          we_q, we_d;
  logic [WW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          hold_q, hold_d;
  logic [31:0]   end_pc_q, end_pc_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic        acc;
  logic [15:0] n_words;

  // Byte acceptance window: header, payload and checksum states only.
  always_comb begin
    bus.in_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                   (state_q == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                   || (state_q == S_CSUM)
`endif
                   ;
  end

  assign acc     = bus.in_valid && bus.in_ready;
  assign n_words = {cnt_hi_q, bus.in_data};

  // Frame parser and write/status next-state logic; restart has top priority.
  always_comb begin
    state_d  = state_q;
    cnt_hi_d = cnt_hi_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    error_d  = error_q;
    hold_d   = hold_q;
    end_pc_d = end_pc_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (bus.restart) begin
      state_d  = S_HDR_HI;
      rem_d    = '0;
      idx_d    = '0;
      bcnt_d   = '0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      hold_d   = 1'b1;
      end_pc_d = ADDR_OFFSET;
`ifdef LOADER_CHECKSUM_EN
      csum_d   = '0;
`endif
    end else begin
      case (state_q)
        S_HDR_HI: if (acc) begin
          cnt_hi_d = bus.in_data;
          state_d  = S_HDR_LO;
        end
        S_HDR_LO: if (acc) begin
          rem_d    = n_words;
          end_pc_d = ADDR_OFFSET + {14'd0, n_words, 2'b00};
          if ({1'b0, n_words} > CAP) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (n_words == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE_WAIT;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: if (acc) begin
          bcnt_d  = bcnt_q + 2'd1;
          shift_d = {shift_q[15:0], bus.in_data};
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.in_data;
`endif
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = {shift_q, bus.in_data};
            idx_d   = idx_q + 1'b1;
            rem_d   = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE_WAIT;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: if (acc) begin
          if (bus.in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
`endif
        S_DONE_WAIT: begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // State and output registers; asynchronous reset discards all progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_HDR_HI;
      cnt_hi_q <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      hold_q   <= 1'b1;
      end_pc_q <= ADDR_OFFSET;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_hi_q <= cnt_hi_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      error_q  <= error_d;
      hold_q   <= hold_d;
      end_pc_q <= end_pc_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.end_pc    = end_pc_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames for imem_loader. The bench derives the
// expected RAM writes and completion status from each frame's bytes
// (count header, big-endian words, XOR checksum when LOADER_CHECKSUM_EN
// is defined) and a per-cycle process checks every write strobe.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(14)) bus ();
  imem_loader #(.ADDR_WIDTH(14), .ADDR_OFFSET(32'h3000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    int unsigned c;
  } wr_t;

  wr_t         exp_q[$];
  logic [11:0] got_a[$];
  logic [31:0] got_d[$];
  logic [7:0]  frm[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Every cycle: a strobe must appear exactly when a write is due, with the
  // model's index and word; status invariants hold throughout.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
      chk("write_missed", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
      chk("mem_we", {31'd0, bus.mem_we}, 32'd1);
      chk("mem_addr", {20'd0, bus.mem_addr}, {20'd0, exp_q[0].a});
      chk("mem_wdata", bus.mem_wdata, exp_q[0].d);
      void'(exp_q.pop_front());
    end else begin
      chk("mem_we_idle", {31'd0, bus.mem_we}, 32'd0);
    end
    if (bus.mem_we) begin
      got_a.push_back(bus.mem_addr);
      got_d.push_back(bus.mem_wdata);
    end
    chk("hold_vs_done", {31'd0, bus.cpu_hold}, {31'd0, ~bus.done});
    chk("ready_when_final", {31'd0, bus.in_ready & (bus.done | bus.error)}, 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit push,
                           input logic [11:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    if (push) exp_q.push_back('{a: a, d: d, c: cyc});
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_restart(input bit with_byte);
    bus.restart  = 1'b1;
    bus.in_valid = with_byte;
    bus.in_data  = 8'h44;
    @(posedge clk);
    #1;
    bus.restart  = 1'b0;
    bus.in_valid = 1'b0;
    chk("restart_done", {31'd0, bus.done}, 32'd0);
    chk("restart_error", {31'd0, bus.error}, 32'd0);
    chk("restart_hold", {31'd0, bus.cpu_hold}, 32'd1);
    chk("restart_ready", {31'd0, bus.in_ready}, 32'd1);
    got_a.delete();
    got_d.delete();
  endtask

  // Send frm (header + payload), appending the checksum when enabled, and
  // check the completion status the frame's contents imply.
  task automatic send_frame(input bit gap, input bit bad_csum);
    int unsigned n;
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    n = {24'd0, frm[0], frm[1]};
    send_byte(frm[0], gap, 1'b0, '0, '0);
    send_byte(frm[1], gap, 1'b0, '0, '0);
    if (n > 4096) begin
      chk("oversize_error", {31'd0, bus.error}, 32'd1);
      chk("oversize_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("oversize_hold", {31'd0, bus.cpu_hold}, 32'd1);
      chk("oversize_done", {31'd0, bus.done}, 32'd0);
      bus.in_valid = 1'b0;
      return;
    end
    for (int unsigned i = 0; i < 4 * n; i++) begin
      x ^= frm[2 + i];
      if (i % 4 == 3) begin
        w = {frm[i - 1], frm[i], frm[i + 1], frm[i + 2]};
        send_byte(frm[2 + i], gap, 1'b1, 12'(i / 4), w);
      end else begin
        send_byte(frm[2 + i], gap, 1'b0, '0, '0);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, 1'b0, 1'b0, '0, '0);
    chk("csum_done", {31'd0, bus.done}, {31'd0, ~bad_csum});
    chk("csum_error", {31'd0, bus.error}, {31'd0, bad_csum});
    chk("csum_hold", {31'd0, bus.cpu_hold}, {31'd0, bad_csum});
`else
    if (!gap) begin
      chk("done_wait_done", {31'd0, bus.done}, 32'd0);
      chk("done_wait_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("frame_done", {31'd0, bus.done}, {31'd0, ~bad_csum});
    chk("frame_hold", {31'd0, bus.cpu_hold}, {31'd0, bad_csum});
`endif
    bus.in_valid = 1'b0;
    if (!bad_csum) chk("end_pc", bus.end_pc, 32'h3000 + 4 * n);
    chk("ready_after_frame", {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic settle;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus.restart  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_hold", {31'd0, bus.cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_error", {31'd0, bus.error}, 32'd0);
    chk("rst_end_pc", bus.end_pc, 32'h3000);
    chk("rst_addr", {20'd0, bus.mem_addr}, 32'd0);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // Two back-to-back words
    frm = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    send_frame(1'b0, 1'b0);
    settle();
    chk("t1_nwrites", got_d.size(), 32'd2);
    if (got_d.size() == 2) begin
      chk("t1_w0", got_d[0], 32'h24080005);
      chk("t1_a1", {20'd0, got_a[1]}, 32'd1);
      chk("t1_w1", got_d[1], 32'h0000000C);
    end
    chk("t1_end_pc", bus.end_pc, 32'h3008);

    // Oversize header: 4097 words
    pulse_restart(1'b0);
    frm = '{8'h10, 8'h01};
    send_frame(1'b0, 1'b0);
    settle();
    chk("t2_nwrites", got_d.size(), 32'd0);
    chk("t2_error_sticky", {31'd0, bus.error}, 32'd1);

    // Single word with in_valid toggling
    pulse_restart(1'b0);
    frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(1'b1, 1'b0);
    settle();
    chk("t3_nwrites", got_d.size(), 32'd1);
    if (got_d.size() == 1) chk("t3_w0", got_d[0], 32'h12345678);

    // Restart mid-word (with a byte offered alongside), then a full frame
    pulse_restart(1'b0);
    send_byte(8'h00, 1'b0, 1'b0, '0, '0);
    send_byte(8'h01, 1'b0, 1'b0, '0, '0);
    send_byte(8'h11, 1'b0, 1'b0, '0, '0);
    send_byte(8'h22, 1'b0, 1'b0, '0, '0);
    send_byte(8'h33, 1'b0, 1'b0, '0, '0);
    pulse_restart(1'b1);
    frm = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(1'b0, 1'b0);
    settle();
    chk("t4_nwrites", got_d.size(), 32'd1);
    if (got_d.size() == 1) begin
      chk("t4_a0", {20'd0, got_a[0]}, 32'd0);
      chk("t4_w0", got_d[0], 32'hAABBCCDD);
    end
    chk("t4_done", {31'd0, bus.done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match (01^02^03^04 = 04) and mismatch (05)
    pulse_restart(1'b0);
    frm = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(1'b0, 1'b0);
    settle();
    chk("t5_done", {31'd0, bus.done}, 32'd1);
    pulse_restart(1'b0);
    send_frame(1'b0, 1'b1);
    settle();
    chk("t5_error", {31'd0, bus.error}, 32'd1);
    chk("t5_hold", {31'd0, bus.cpu_hold}, 32'd1);
    chk("t5_nwrites", got_d.size(), 32'd1);
`endif

    // Empty image
    pulse_restart(1'b0);
    frm = '{8'h00, 8'h00};
    send_frame(1'b0, 1'b0);
    settle();
    chk("t6_nwrites", got_d.size(), 32'd0);
    chk("t6_end_pc", bus.end_pc, 32'h3000);

    // Asynchronous reset mid-word
    pulse_restart(1'b0);
    send_byte(8'h00, 1'b0, 1'b0, '0, '0);
    send_byte(8'h01, 1'b0, 1'b0, '0, '0);
    send_byte(8'hAA, 1'b0, 1'b0, '0, '0);
    send_byte(8'hBB, 1'b0, 1'b0, '0, '0);
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("arst_addr", {20'd0, bus.mem_addr}, 32'd0);
    chk("arst_wdata", bus.mem_wdata, 32'd0);
    chk("arst_hold", {31'd0, bus.cpu_hold}, 32'd1);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_error", {31'd0, bus.error}, 32'd0);
    chk("arst_end_pc", bus.end_pc, 32'h3000);
    chk("arst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    got_a.delete();
    got_d.delete();
    frm = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(1'b0, 1'b0);
    settle();
    chk("t7_nwrites", got_d.size(), 32'd1);
    if (got_d.size() == 1) begin
      chk("t7_a0", {20'd0, got_a[0]}, 32'd0);
      chk("t7_w0", got_d[0], 32'hDEADBEEF);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("pending_writes", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
